// File: rtl/fifo_ctrl_pkg.sv
// Shared widths and op-state encodings for the 8-entry FIFO control stage.
// Imported by the interface, the next-state logic and the register stage.
package fifo_ctrl_pkg;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  // 3'b011 and 3'b100 are deliberately left unused by the flag decoder.
  typedef enum logic [2:0] {
    ST_INIT   = 3'b000,
    ST_WRITE  = 3'b001,
    ST_READ   = 3'b010,
    ST_WR_ERR = 3'b101,
    ST_RD_ERR = 3'b110,
    ST_NO_OP  = 3'b111
  } state_t;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between the FIFO requester and the control stage.
// master issues wr_en/rd_en; slave (fifo_ctrl) returns op state, count, pointers and strobes.
interface fifo_ctrl_if;
  import fifo_ctrl_pkg::*;

  logic          wr_en;
  logic          rd_en;
  state_t        state;
  logic [CW-1:0] data_count;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          we;
  logic          re;

  modport master (
    output wr_en, rd_en,
    input  state, data_count, head, tail, we, re
  );

  modport slave (
    input  wr_en, rd_en,
    output state, data_count, head, tail, we, re
  );

endinterface

// File: rtl/fifo_ctrl_ns.sv
// Combinational next-state, next-count and next-pointer decode; zero latency.
// No backpressure: over/underflow requests become error states with no update.
module fifo_ctrl_ns
  import fifo_ctrl_pkg::*;
(
  input  logic          wr_en,
  input  logic          rd_en,
  input  state_t        state,
  input  logic [CW-1:0] data_count,
  input  logic [AW-1:0] head,
  input  logic [AW-1:0] tail,
  output state_t        nxt_state,
  output logic [CW-1:0] nxt_count,
  output logic [AW-1:0] nxt_head,
  output logic [AW-1:0] nxt_tail
);

  logic full;
  logic empty;

  // Occupancy alone decides full/empty; head==tail is ambiguous at both ends.
  assign full  = (data_count == CW'(DEPTH));
  assign empty = (data_count == '0);

  always_comb begin
    nxt_state = state;
    nxt_count = data_count;
    nxt_head  = head;
    nxt_tail  = tail;
    unique case ({wr_en, rd_en})
      2'b10: begin
        if (full) begin
          nxt_state = ST_WR_ERR;
        end else begin
          nxt_state = ST_WRITE;
          nxt_tail  = tail + AW'(1);
          nxt_count = data_count + CW'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          nxt_state = ST_RD_ERR;
        end else begin
          nxt_state = ST_READ;
          nxt_head  = head + AW'(1);
          nxt_count = data_count - CW'(1);
        end
      end
      2'b11: nxt_state = ST_NO_OP;
      default: nxt_state = (state == ST_INIT) ? ST_INIT : ST_NO_OP;
    endcase
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control registers: op state, occupancy and head/tail; state/count one cycle after request.
// No backpressure: requests sampled every cycle, we/re strobes combinational on the request cycle.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
(
  input logic         clk,
  input logic         rst,
  fifo_ctrl_if.slave  bus
);

  state_t        state_q;
  state_t        nxt_state;
  logic [CW-1:0] count_q;
  logic [CW-1:0] nxt_count;
  logic [AW-1:0] head_q;
  logic [AW-1:0] nxt_head;
  logic [AW-1:0] tail_q;
  logic [AW-1:0] nxt_tail;

  fifo_ctrl_ns u_ns (
    .wr_en      (bus.wr_en),
    .rd_en      (bus.rd_en),
    .state      (state_q),
    .data_count (count_q),
    .head       (head_q),
    .tail       (tail_q),
    .nxt_state  (nxt_state),
    .nxt_count  (nxt_count),
    .nxt_head   (nxt_head),
    .nxt_tail   (nxt_tail)
  );

  // Reset drops any same-cycle request outright.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= nxt_state;
      count_q <= nxt_count;
      head_q  <= nxt_head;
      tail_q  <= nxt_tail;
    end
  end

  assign bus.we = ~rst & bus.wr_en & ~bus.rd_en & (count_q != CW'(DEPTH));
  assign bus.re = ~rst & bus.rd_en & ~bus.wr_en & (count_q != '0);

  assign bus.state      = state_q;
  assign bus.data_count = count_q;
  assign bus.head       = head_q;
  assign bus.tail       = tail_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboarded bench for fifo_ctrl: directed scenarios then biased random traffic,
// expectations from an occupancy/request-count model of the FIFO.
module tb_fifo_ctrl;

  localparam int E_INIT   = 0;
  localparam int E_WRITE  = 1;
  localparam int E_READ   = 2;
  localparam int E_WR_ERR = 5;
  localparam int E_RD_ERR = 6;
  localparam int E_NO_OP  = 7;
  localparam int N        = 8;

  typedef struct {
    int we;
    int re;
    int st;
    int cnt;
    int hd;
    int tl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_ctrl_if bus ();

  fifo_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: occupancy as a token queue, pointers as total transfers since reset.
  int   tokens[$];
  int   wr_total = 0;
  int   rd_total = 0;
  int   m_state  = E_INIT;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit w, input bit d);
    exp_t e;
    @(negedge clk);
    rst       = r;
    bus.wr_en = w;
    bus.rd_en = d;
    e.we = (!r && w && !d && tokens.size() < N) ? 1 : 0;
    e.re = (!r && d && !w && tokens.size() > 0) ? 1 : 0;
    if (r) begin
      tokens.delete();
      wr_total = 0;
      rd_total = 0;
      m_state  = E_INIT;
    end else if (w && !d) begin
      if (tokens.size() < N) begin
        tokens.push_back(wr_total);
        wr_total++;
        m_state = E_WRITE;
      end else begin
        m_state = E_WR_ERR;
      end
    end else if (d && !w) begin
      if (tokens.size() > 0) begin
        void'(tokens.pop_front());
        rd_total++;
        m_state = E_READ;
      end else begin
        m_state = E_RD_ERR;
      end
    end else if (w && d) begin
      m_state = E_NO_OP;
    end else if (m_state != E_INIT) begin
      m_state = E_NO_OP;
    end
    e.st  = m_state;
    e.cnt = tokens.size();
    e.hd  = rd_total % N;
    e.tl  = wr_total % N;
    exp_q.push_back(e);
  endtask

  task automatic rep(input int n, input bit r, input bit w, input bit d);
    for (int i = 0; i < n; i++) cyc(r, w, d);
  endtask

  // Monitor: strobes checked mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("we", int'(bus.we), e.we);
        check("re", int'(bus.re), e.re);
        @(posedge clk);
        #1;
        check("state", int'(bus.state), e.st);
        check("data_count", int'(bus.data_count), e.cnt);
        check("head", int'(bus.head), e.hd);
        check("tail", int'(bus.tail), e.tl);
      end
    end
  end

  initial begin
    int p_wr;
    int p_rd;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;

    // Reset holds with a write pending.
    rep(2, 1, 1, 0);
    // Idle stays in INIT.
    rep(2, 0, 0, 0);
    // Fill, wrap tail, then overflow.
    rep(8, 0, 1, 0);
    rep(1, 0, 1, 0);
    rep(1, 0, 0, 0);
    // Underflow from empty, then simultaneous request at count 3.
    rep(1, 1, 0, 0);
    rep(1, 0, 0, 1);
    rep(3, 0, 1, 0);
    rep(1, 0, 1, 1);
    // Wrap both pointers.
    rep(1, 1, 0, 0);
    rep(8, 0, 1, 0);
    rep(3, 0, 0, 1);
    rep(3, 0, 1, 0);
    rep(8, 0, 0, 1);
    rep(1, 0, 0, 1);
    // Reset mid-write at count 5, then resume.
    rep(1, 1, 0, 0);
    rep(5, 0, 1, 0);
    rep(1, 1, 1, 0);
    rep(1, 0, 1, 0);
    // Simultaneous request straight out of INIT.
    rep(1, 1, 0, 0);
    rep(1, 0, 1, 1);

    // Random traffic in phases biased toward full, empty and balanced.
    for (int ph = 0; ph < 6; ph++) begin
      p_wr = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      p_rd = 100 - p_wr;
      for (int i = 0; i < 300; i++) begin
        cyc($urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < p_wr,
            $urandom_range(0, 99) < p_rd);
      end
    end

    @(negedge clk);
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d expected=0", exp_q.size());
    $fatal(1, "bench timeout");
  end

endmodule
